// File: rtl/adc_filt_pkg.sv
// ============================================================================
// Module      : adc_filt_pkg
// Description : Shared width, state encoding and default hysteresis levels
//               for the ADC sample averaging filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_filt_pkg;

    localparam int ADC_W = 12;

    localparam logic [ADC_W-1:0] c_thresh_hi_default = 12'd3000;
    localparam logic [ADC_W-1:0] c_thresh_lo_default = 12'd1000;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        LAST = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/adc_hyst_cmp.sv
// ============================================================================
// Module      : adc_hyst_cmp
// Description : Hysteresis comparator evaluated only when a new value loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_hyst_cmp
    import adc_filt_pkg::*;
#(
    parameter logic [ADC_W-1:0] THRESH_HI = c_thresh_hi_default,
    parameter logic [ADC_W-1:0] THRESH_LO = c_thresh_lo_default
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [ADC_W-1:0] value,
    output logic             over
);

    logic r_over;

    // Between the two levels the previous decision is kept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_over <= 1'b0;
        end else if (load) begin
            if (value >= THRESH_HI) begin
                r_over <= 1'b1;
            end else if (value <= THRESH_LO) begin
                r_over <= 1'b0;
            end
        end
    end

    assign over = r_over;

endmodule

`default_nettype wire

// File: rtl/adc_sample_filter.sv
// ============================================================================
// Module      : adc_sample_filter
// Description : Block average of 2^LOG2_N ADC samples with valid/ready
//               output, sticky overrun and hysteresis flag.
//               Define ADC_FILT_MINMAX_EN to add per-window win_min/win_max.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sample_filter
    import adc_filt_pkg::*;
#(
    parameter int               LOG2_N    = 4,
    parameter logic [ADC_W-1:0] THRESH_HI = c_thresh_hi_default,
    parameter logic [ADC_W-1:0] THRESH_LO = c_thresh_lo_default
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [ADC_W-1:0] sample,
    input  logic             sample_stb,
    output logic [ADC_W-1:0] avg,
    output logic             avg_valid,
    input  logic             avg_ready,
    input  logic             clr_ovr,
    output logic             over,
`ifdef ADC_FILT_MINMAX_EN
    output logic [ADC_W-1:0] win_min,
    output logic [ADC_W-1:0] win_max,
`endif
    output logic             overrun
);

    localparam int              c_acc_w    = ADC_W + LOG2_N;
    localparam logic [LOG2_N-1:0] c_last_cnt = LOG2_N'((1 << LOG2_N) - 2);

    state_t             r_state;
    logic [c_acc_w-1:0] r_acc;
    logic [LOG2_N-1:0]  r_cnt;
    logic [ADC_W-1:0]   r_avg;
    logic               r_avg_valid;
    logic               r_overrun;

    logic [c_acc_w-1:0] w_sum;
    logic [ADC_W-1:0]   w_new_avg;
    logic               w_complete;
    logic               w_accept;

    // Full window of maximum samples is N*4095, which fits c_acc_w bits.
    assign w_sum      = r_acc + c_acc_w'(sample);
    assign w_new_avg  = ADC_W'(w_sum >> LOG2_N);
    assign w_complete = sample_stb && (r_state == LAST);
    assign w_accept   = r_avg_valid && avg_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (sample_stb) begin
            case (r_state)
                ACC: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + LOG2_N'(1);
                    if (r_cnt == c_last_cnt) begin
                        r_state <= LAST;
                    end
                end
                LAST: begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= ACC;
                end
                default: r_state <= ACC;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_complete) begin
                r_avg       <= w_new_avg;
                r_avg_valid <= 1'b1;
            end else if (w_accept) begin
                r_avg_valid <= 1'b0;
            end
            // A fresh overwrite outranks a simultaneous clear.
            if (w_complete && r_avg_valid && !avg_ready) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign avg       = r_avg;
    assign avg_valid = r_avg_valid;
    assign overrun   = r_overrun;

    adc_hyst_cmp #(
        .THRESH_HI (THRESH_HI),
        .THRESH_LO (THRESH_LO)
    ) u_hyst (
        .clock (clock),
        .reset (reset),
        .load  (w_complete),
        .value (w_new_avg),
        .over  (over)
    );

`ifdef ADC_FILT_MINMAX_EN
    logic [ADC_W-1:0] r_run_min;
    logic [ADC_W-1:0] r_run_max;
    logic [ADC_W-1:0] r_win_min;
    logic [ADC_W-1:0] r_win_max;
    logic             w_first;
    logic [ADC_W-1:0] w_min;
    logic [ADC_W-1:0] w_max;

    // The first sample of a window re-seeds both running trackers.
    assign w_first = (r_state == ACC) && (r_cnt == '0);
    assign w_min   = (w_first || (sample < r_run_min)) ? sample : r_run_min;
    assign w_max   = (w_first || (sample > r_run_max)) ? sample : r_run_max;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_run_min <= '0;
            r_run_max <= '0;
            r_win_min <= '0;
            r_win_max <= '0;
        end else if (sample_stb) begin
            r_run_min <= w_min;
            r_run_max <= w_max;
            if (w_complete) begin
                r_win_min <= w_min;
                r_win_max <= w_max;
            end
        end
    end

    assign win_min = r_win_min;
    assign win_max = r_win_max;
`endif

endmodule

`default_nettype wire
